decode_regfile_stage: RTL

DECODE_REGFILE_STAGE -- requirements
Module: decode_regfile_stage

---
 rtl/decode_regfile_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/decode_regfile_stage.sv
// rtl/decode_regfile_stage.sv - MIPS decode stage with register file and a one-deep registered output slot
// Define DECODE_WB_BYPASS_EN to forward same-edge writeback data into the captured operands.
module decode_regfile_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opcode,
    output logic [AW-1:0]   out_rs,
    output logic [AW-1:0]   out_rt,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_data1,
    output logic [XLEN-1:0] out_data2,
    output logic [XLEN-1:0] out_imm
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic            r_valid;
    logic [5:0]      r_opcode;
    logic [AW-1:0]   r_rs;
    logic [AW-1:0]   r_rt;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic [XLEN-1:0] r_imm;

    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rf_data1;
    logic [XLEN-1:0] w_rf_data2;
    logic [XLEN-1:0] w_data1;
    logic [XLEN-1:0] w_data2;
    logic            w_we;
    logic            w_xfer;

    assign w_rs = instr[21 +: AW];
    assign w_rt = instr[16 +: AW];
    assign w_rd = instr[11 +: AW];

    generate
        if (XLEN <= 16) begin : g_imm_narrow
            assign w_imm = instr[XLEN-1:0];
        end else begin : g_imm_wide
            assign w_imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
    endgenerate

    // Register 0 is never written and resets to zero, so it always reads as zero.
    assign w_we       = wb_en && (wb_addr != '0);
    assign w_rf_data1 = r_regs[w_rs];
    assign w_rf_data2 = r_regs[w_rt];

`ifdef DECODE_WB_BYPASS_EN
    assign w_data1 = (w_we && (wb_addr == w_rs)) ? wb_data : w_rf_data1;
    assign w_data2 = (w_we && (wb_addr == w_rt)) ? wb_data : w_rf_data2;
`else
    assign w_data1 = w_rf_data1;
    assign w_data2 = w_rf_data2;
`endif

    // Flush empties the slot at the next edge, so accepting is always safe while it is asserted.
    assign in_ready = !r_valid || out_ready || flush;
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Operands are sampled only on acceptance, so a held bundle ignores later writebacks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            r_imm    <= '0;
        end else if (w_xfer && !flush) begin
            r_opcode <= instr[31:26];
            r_rs     <= w_rs;
            r_rt     <= w_rt;
            r_rd     <= w_rd;
            r_data1  <= w_data1;
            r_data2  <= w_data2;
            r_imm    <= w_imm;
        end
    end

    assign out_valid  = r_valid;
    assign out_opcode = r_opcode;
    assign out_rs     = r_rs;
    assign out_rt     = r_rt;
    assign out_rd     = r_rd;
    assign out_data1  = r_data1;
    assign out_data2  = r_data2;
    assign out_imm    = r_imm;

endmodule
